// File: rtl/uart_baud_counter_if.sv
// Control/status bundle for uart_baud_counter; the frac signal exists only when
// UART_BAUD_COUNTER_FRAC_EN is defined.
interface uart_baud_counter_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FRAC_WIDTH = 4
);
  logic [WIDTH-1:0]      divisor;
`ifdef UART_BAUD_COUNTER_FRAC_EN
  logic [FRAC_WIDTH-1:0] frac;
`endif
  logic                  start;
  logic                  half;
  logic                  stop;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  tick;
  logic                  err;

  if (WIDTH < 2 || FRAC_WIDTH < 1) begin : g_param_check
    $error("uart_baud_counter_if: WIDTH must be >= 2 and FRAC_WIDTH >= 1");
  end

  modport master (
`ifdef UART_BAUD_COUNTER_FRAC_EN
    output frac,
`endif
    output divisor, start, half, stop,
    input  count, busy, tick, err
  );

  modport slave (
`ifdef UART_BAUD_COUNTER_FRAC_EN
    input  frac,
`endif
    input  divisor, start, half, stop,
    output count, busy, tick, err
  );
endinterface

// File: rtl/uart_baud_counter.sv
// Self-reloading UART bit-timing down-counter with half-period first interval and
// divisor error detection. Define UART_BAUD_COUNTER_FRAC_EN for fractional periods.
module uart_baud_counter #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FRAC_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_baud_counter_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] count_q, count_nx;
  logic [WIDTH-1:0] half_div, first_load, reload;
  logic             tick_q, tick_nx;
  logic             err_q, err_nx;

  if (WIDTH < 2 || FRAC_WIDTH < 1) begin : g_param_check
    $error("uart_baud_counter: WIDTH must be >= 2 and FRAC_WIDTH >= 1");
  end

  // Half mode loads max(divisor>>1,1)-1 so the first tick lands mid-bit.
  assign half_div   = bus.divisor >> 1;
  assign first_load = !bus.half        ? bus.divisor - WIDTH'(1) :
                      (half_div == '0) ? '0 : half_div - WIDTH'(1);

`ifdef UART_BAUD_COUNTER_FRAC_EN
  logic [FRAC_WIDTH-1:0] acc_q, acc_nx;
  logic [FRAC_WIDTH:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, bus.frac};
  // Accumulator carry stretches this period by one cycle.
  assign reload  = acc_sum[FRAC_WIDTH] ? bus.divisor : bus.divisor - WIDTH'(1);
`else
  assign reload  = bus.divisor - WIDTH'(1);
`endif

  always_comb begin
    state_nx = state;
    count_nx = count_q;
    tick_nx  = 1'b0;
    err_nx   = 1'b0;
`ifdef UART_BAUD_COUNTER_FRAC_EN
    acc_nx   = acc_q;
`endif
    if (bus.stop) begin
      state_nx = IDLE;
      count_nx = '0;
    end else if (bus.start) begin
      if (bus.divisor == '0) begin
        state_nx = IDLE;
        count_nx = '0;
        err_nx   = 1'b1;
      end else begin
        state_nx = RUN;
        count_nx = first_load;
`ifdef UART_BAUD_COUNTER_FRAC_EN
        acc_nx   = '0;
`endif
      end
    end else if (state == RUN) begin
      if (count_q != '0) begin
        count_nx = count_q - WIDTH'(1);
      end else begin
        tick_nx = 1'b1;
        if (bus.divisor == '0) begin
          state_nx = IDLE;
          count_nx = '0;
          err_nx   = 1'b1;
        end else begin
          count_nx = reload;
`ifdef UART_BAUD_COUNTER_FRAC_EN
          acc_nx   = acc_sum[FRAC_WIDTH-1:0];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      count_q <= count_nx;
      tick_q  <= tick_nx;
      err_q   <= err_nx;
    end
  end

`ifdef UART_BAUD_COUNTER_FRAC_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_nx;
  end
`endif

  assign bus.count = count_q;
  assign bus.busy  = (state == RUN);
  assign bus.tick  = tick_q;
  assign bus.err   = err_q;

endmodule

// File: doc/uart_baud_counter.md
Name: uart_baud_counter

Overview:
Parametrised, self-reloading down-counter that generates UART bit-timing ticks. It replaces the fixed 16-bit combinational decrement used for the rx_clks counter with a full registered block. The block adds load, start, stop and half-period first-interval (mid-bit sampling) control, plus divisor error detection. It is instantiated once per UART direction, with tx using the full-period mode and rx using the half-period mode.

Parameters:
WIDTH, 16, counter and divisor width in bits (>=2)
FRAC_WIDTH, 4, fractional accumulator width; used only with UART_BAUD_COUNTER_FRAC_EN

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
divisor  input  WIDTH  tick period in clk cycles; sampled at start and at every reload
frac  input  FRAC_WIDTH  fractional period increment in 1/2^FRAC_WIDTH cycles; present only with UART_BAUD_COUNTER_FRAC_EN
start  input  1  single-cycle pulse: begin or restart counting
half  input  1  sampled with start; 1 = first interval is half period
stop  input  1  single-cycle pulse: return to idle
count  output  WIDTH  current down-counter value
busy  output  1  high while in RUN
tick  output  1  registered one-cycle pulse at each period boundary
err  output  1  registered one-cycle pulse when start is seen with divisor==0

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, count=0, busy=0, tick=0, err=0, frac accumulator=0.
- States: IDLE, RUN. busy is registered and equals (state==RUN).
- Priority at a clock edge: stop > start > normal count.
- IDLE:
  - count holds 0 and tick=0.
  - On start with divisor!=0: count <= first-load value, go to RUN, accumulator <= 0.
  - On start with divisor==0: stay in IDLE and pulse err for 1 cycle.
- First-load value:
  - half=0: divisor-1.
  - half=1: max(divisor>>1, 1)-1. Example: divisor=1 loads 0; divisor=7 loads 2.
- RUN, count!=0: count <= count-1 (WIDTH-bit unsigned; never wraps because 0 reloads).
- RUN, count==0: count <= reload value and tick <= 1 on the same edge.
  - Reload value is divisor-1, using the current divisor.
  - If the current divisor==0: go to IDLE and pulse err; tick is still asserted for this boundary.
- Tick period in full mode is exactly divisor cycles. The first tick is registered high at the rising edge occurring divisor cycles after the start edge. In half mode the first tick occurs max(divisor>>1,1) cycles after the start edge.
- divisor=1: tick is high every cycle while in RUN.
- start while in RUN: restart. The first-load value is recomputed, the accumulator is cleared, no tick is produced on that edge, and busy stays 1.
- stop (any state): next edge gives state=IDLE, count=0, tick=0. A tick already registered is not extended.
- stop and start in the same cycle: stop wins and the block ends in IDLE.
- Reset asserted mid-RUN: all outputs go to their reset values immediately, with no tick.
- tick and err are never high for more than one consecutive cycle, except tick when divisor=1.

Optional Feature:
Macro: UART_BAUD_COUNTER_FRAC_EN
- Defined:
  - The frac port exists and a FRAC_WIDTH-bit accumulator is added.
  - At every RUN reload: {carry, acc} <= acc + frac.
  - If carry=1, the reload value is divisor instead of divisor-1 (one extra cycle).
  - The average period is divisor + frac/2^FRAC_WIDTH.
  - The accumulator is not updated by the first load.
- Not defined: no frac port, no accumulator, and the period is exactly divisor. All other behaviour is identical.

Test Plan:
- Reset then start with divisor=5, half=0 -> busy=1 next cycle; tick at cycles 5, 10, 15 after start; count sequence 4,3,2,1,0,4…
- start with divisor=8, half=1 -> first tick 4 cycles after start, then every 8 cycles; start with divisor=1, half=1 -> tick every cycle.
- divisor=0 with start -> err pulse 1 cycle, busy stays 0, count=0. Change divisor to 0 mid-RUN -> at next boundary tick=1, err=1, then IDLE.
- In RUN with divisor=10: stop at count=3 -> IDLE, count=0, no tick. Same-cycle stop+start -> IDLE. start at count=3 -> count reloads to 9, no tick.
- Assert reset_n low asynchronously mid-period (between clock edges) -> count, busy, tick and err go to 0 before the next edge; after release the block stays idle until start.
- FRAC_EN with divisor=4, frac=8, FRAC_WIDTH=4 -> tick intervals after the first alternate 4,5,4,5 (average 4.5); frac=0 -> constant 4.
